srl_fifo: RTL and testbench

- Synchronous FIFO whose storage is a single addressable shift-register chain, so synthesis maps it onto Xilinx SRL primitives.
- Sits directly downstream of a fixed delay chain (single-bit or vector shift registers). It buffers that chain's output stream and provides valid/ready back-pressure to the consumer.
- Storage has no reset and is written in one shift per push, so SRL inference works. Only the occupancy counter is reset.

---
 rtl/srl_fifo.sv | 73 +++++++
 tb/tb_srl_fifo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/srl_fifo.sv
// Synchronous FIFO whose storage is a single addressable shift chain, so it maps
// onto SRL primitives; only the occupancy counter is reset.
module srl_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] srl [DEPTH];
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [AW-1:0]    tap;
  logic             push;
  logic             pop;

  // Flags come only from the registered count, so no input reaches an output.
  assign in_ready  = (count_reg != CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // The head sits at tap count-1; when empty the index wraps and out_data is unused.
  assign tap      = AW'(count_reg - CW'(1));
  assign out_data = srl[tap];
  assign count    = count_reg;

  // Shift chain: no reset and a single write path keep it SRL-friendly.
  always_ff @(posedge clk) begin
    if (push) begin
      srl[0] <= in_data;
    end
  end

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_chain
      always_ff @(posedge clk) begin
        if (push) begin
          srl[gi] <= srl[gi-1];
        end
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_srl_fifo.sv
// Directed bench for srl_fifo: reset, fill, drain, simultaneous push/pop,
// full boundary and reset mid-stream, with hand-computed expectations.
module tb_srl_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  int tests_run    = 0;
  int tests_failed = 0;

  srl_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    out_ready = 1'b0;

    // Reset then idle
    tick();
    tick();
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    check("idle_count", 32'(count), 0);

    // Fill 0x01..0x10
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 1);
      tick();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_in_ready", 32'(in_ready), (i + 1 == DEPTH) ? 0 : 1);
    end
    in_data = 8'hAA;
    tick();
    check("full_reject_count", 32'(count), 16);
    check("full_head", 32'(out_data), 32'h01);
    in_valid = 1'b0;

    // Drain from full
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_valid", 32'(out_valid), 1);
      check("drain_data", 32'(out_data), 32'(i + 1));
      tick();
      check("drain_count", 32'(count), 32'(DEPTH - 1 - i));
    end
    check("empty_out_valid", 32'(out_valid), 0);
    tick();
    check("empty_pop_count", 32'(count), 0);
    out_ready = 1'b0;

    // Simultaneous push/pop at count 5
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h11 + i);
      tick();
    end
    check("preload_count", 32'(count), 5);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(8'h20 + i);
      check("pp_data", 32'(out_data), (i < 5) ? 32'(8'h11 + i) : 32'(8'h20 + i - 5));
      tick();
      check("pp_count", 32'(count), 5);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("pp_drain_data", 32'(out_data), 32'(8'h25 + i));
      tick();
    end
    check("pp_drain_count", 32'(count), 0);
    out_ready = 1'b0;

    // Full boundary: push ignored while full even with a pop
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h40 + i);
      tick();
    end
    check("fb_full_count", 32'(count), 16);
    in_data   = 8'h99;
    out_ready = 1'b1;
    check("fb_head", 32'(out_data), 32'h40);
    tick();
    check("fb_count", 32'(count), 15);
    check("fb_in_ready", 32'(in_ready), 1);
    out_ready = 1'b0;
    in_data   = 8'h77;
    tick();
    check("fb_refill_count", 32'(count), 16);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("fb_drain_data", 32'(out_data), (i < 15) ? 32'(8'h41 + i) : 32'h77);
      tick();
    end
    check("fb_drain_count", 32'(count), 0);
    out_ready = 1'b0;

    // Reset mid-stream at count 7, with a push in the reset cycle
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h60 + i);
      tick();
    end
    check("mid_count", 32'(count), 7);
    rst     = 1'b1;
    in_data = 8'h5A;
    tick();
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    rst     = 1'b0;
    in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    check("post_rst_data", 32'(out_data), 32'h3C);
    check("post_rst_count", 32'(count), 1);
    check("post_rst_out_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    check("post_rst_pop_count", 32'(count), 0);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
